ir_camera_target: RTL
=====================

# ir_camera_target

I2C target (slave) that emulates the IR position camera at bus address 0x58: it accepts the configuration writes and data-request pointer writes issued by the camera controller, and answers 16-byte reads with a coherent snapshot of one blob's position. Used as the bus-level counterpart of the camera controller in system simulation, and on FPGA as a drop-in synthetic camera fed from a test pattern source.

## Interface
Parameters:
- ADDR, 7'h58, 7-bit target address matched after START
- SNAP_BASE, 8'h36, register pointer value that maps to snapshot byte 0

Ports:
- clk  in  1  system clock, at least 16x SCL frequency
- reset  in  1  synchronous, active-low; all state is cleared on the clk edge where reset=0
- i2c_scl  in  1  bus clock from initiator (no clock stretching)
- i2c_sda_in  in  1  sampled bus data
- i2c_sda  out  1  open-drain drive: 0 = pull low, 1 = release
- x  in  10  blob X position
- y  in  10  blob Y position
- size  in  4  blob size
- reg_wr  out  1  one-cycle pulse per written data byte
- reg_addr  out  8  pointer value of the byte written (valid with reg_wr)
- reg_data  out  8  data byte written (valid with reg_wr)
- ctrl  out  8  last byte written to register 0x30
- mode  out  8  last byte written to register 0x33
- enabled  out  1  ctrl[3]
- busy  out  1  high from address match (ACK) until STOP, or until a non-matching address is rejected

## Operation
- Input conditioning: i2c_scl and i2c_sda_in pass 2-FF synchronizers; edges detected against a third registered copy.
- START: SDA falling while SCL high and SCL had no edge that cycle. STOP: SDA rising under the same condition. If SCL and SDA edges occur in the same cycle, handle only the SCL edge.
- Bits are sampled on SCL rising and i2c_sda is updated on SCL falling, MSB first.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- IDLE -> ADDR on START. START in any state (repeated START) -> ADDR, bit count cleared, SDA released.
- STOP in any state -> IDLE, SDA released, busy=0.
- ADDR: after 8 bits, if addr==ADDR -> ADDR_ACK (drive ACK), else -> IGNORE (no ACK; wait for START/STOP).
- R/W=0: ADDR_ACK -> WR_BYTE. First byte of a write transaction loads the pointer; no reg_wr. Each later byte: pulse reg_wr with reg_addr=pointer, update ctrl if pointer==0x30 and mode if pointer==0x33, pointer+1. Every byte is ACKed (WR_ACK) and followed by a return to WR_BYTE.
- R/W=1: on address match, latch snapshot from x/y/size in the same cycle (coherent for the whole read). ADDR_ACK -> RD_BYTE. Byte sent = snapshot[pointer-SNAP_BASE] when 0<=index<=15, else 0x00. Pointer+1 after each byte. RD_ACK samples initiator: ACK -> RD_BYTE, NACK -> IGNORE.
- Snapshot bytes: 0 = x[7:0]; 1 = y[7:0]; 2 = {y[9:8], x[9:8], size}; 3..15 = 0xFF (unused blobs).
- Pointer is 8 bits, wraps 0xFF->0x00; it persists across transactions (so a pointer-only write followed by a read starts at that pointer).
- Reset values: i2c_sda=1, reg_wr=0, reg_addr=0, reg_data=0, ctrl=0, mode=0, enabled=0, busy=0, pointer=0, snapshot=0, state IDLE. Reset asserted mid-transaction releases SDA on that edge; the block then ignores the bus until the next START.

## Timing
- Pin-to-event latency: 3 clk (2 sync + 1 edge register).
- i2c_sda changes on the clk edge after the SCL falling edge is detected, i.e. 4 clk after the pin falls.
- ACK: SDA held low from the falling edge after bit 8 until the falling edge after bit 9.
- Read data: bit 7 is driven from the falling edge that ends ADDR_ACK/RD_ACK, and each bit is held until the next SCL falling edge.
- reg_wr pulses for exactly 1 clk, on the cycle the 8th bit is sampled; ctrl/mode update in that same cycle.
- busy rises together with the first ACK drive and falls the cycle after STOP detection.

## Test plan
- Write 0x58/W, 0x30, 0x01; STOP; then 0x58/W, 0x30, 0x08 -> two reg_wr pulses (addr 0x30, data 0x01 then 0x08), ctrl=0x08, enabled=1, all bytes ACKed.
- Write 0x58/W, 0x33, 0x33 -> mode=0x33, one reg_wr, busy drops after STOP.
- x=0x2A5, y=0x17C, size=5; write pointer 0x36; read 16 bytes -> A5, 7C, 0x65, then thirteen 0xFF; NACK on the last byte releases SDA.
- Change x mid-read -> remaining bytes still from the latched snapshot; the next read shows the new value.
- Address 0x21 -> no ACK, SDA stays 1, busy=0, no reg_wr until the next valid START.
- Reset low during read bit 3 -> i2c_sda=1 on the next clk; all outputs at reset values; a new valid transaction succeeds.

Source files
------------

// File: rtl/ir_camera_target.sv
// ir_camera_target: I2C target emulating the IR position camera at address ADDR.
// Accepts register writes and serves 16-byte coherent blob snapshots on reads.
module ir_camera_target #(
    parameter logic [6:0] ADDR      = 7'h58,
    parameter logic [7:0] SNAP_BASE = 8'h36
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [3:0] size,
    output logic       reg_wr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic [7:0] ctrl,
    output logic [7:0] mode,
    output logic       enabled,
    output logic       busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
    } state_t;

    logic [1:0] r_scl_sync, r_sda_sync;
    logic       r_scl_d, r_sda_d;
    logic       r_scl_rise, r_scl_fall, r_start, r_stop;
    logic       w_scl_s, w_sda_s, w_scl_edge;

    assign w_scl_s    = r_scl_sync[1];
    assign w_sda_s    = r_sda_sync[1];
    assign w_scl_edge = w_scl_s ^ r_scl_d;

    // Synchronizers preset to the idle (released) bus level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i2c_scl};
            r_sda_sync <= {r_sda_sync[0], i2c_sda_in};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
            r_scl_rise <= w_scl_s & ~r_scl_d;
            r_scl_fall <= ~w_scl_s & r_scl_d;
            r_start    <= ~w_scl_edge & w_scl_s & r_sda_d & ~w_sda_s;
            r_stop     <= ~w_scl_edge & w_scl_s & ~r_sda_d & w_sda_s;
        end
    end

    state_t      r_state, n_state;
    logic [2:0]  r_bitcnt, n_bitcnt;
    logic [7:0]  r_shift, n_shift;
    logic [7:0]  r_tx, n_tx;
    logic        r_ack_clk, n_ack_clk;
    logic        r_rw, n_rw;
    logic        r_first, n_first;
    logic [7:0]  r_ptr, n_ptr;
    logic [23:0] r_snap, n_snap;
    logic        r_sda, n_sda;
    logic        r_busy, n_busy;
    logic [7:0]  r_ctrl, n_ctrl;
    logic [7:0]  r_mode, n_mode;
    logic        r_wr, n_wr;
    logic [7:0]  r_waddr, n_waddr;
    logic [7:0]  r_wdata, n_wdata;

    logic [7:0]  w_byte, w_idx, w_rd_byte;

    assign w_byte = {r_shift[6:0], r_sda_d};
    assign w_idx  = r_ptr - SNAP_BASE;

    always_comb begin
        w_rd_byte = 8'h00;
        if (w_idx < 8'd16) begin
            case (w_idx)
                8'd0:    w_rd_byte = r_snap[7:0];
                8'd1:    w_rd_byte = r_snap[15:8];
                8'd2:    w_rd_byte = r_snap[23:16];
                default: w_rd_byte = 8'hFF;
            endcase
        end
    end

    // Each ACK state spans two SCL falls: r_ack_clk marks that the ninth rise was seen.
    always_comb begin
        n_state   = r_state;
        n_bitcnt  = r_bitcnt;
        n_shift   = r_shift;
        n_tx      = r_tx;
        n_ack_clk = r_ack_clk;
        n_rw      = r_rw;
        n_first   = r_first;
        n_ptr     = r_ptr;
        n_snap    = r_snap;
        n_sda     = r_sda;
        n_busy    = r_busy;
        n_ctrl    = r_ctrl;
        n_mode    = r_mode;
        n_wr      = 1'b0;
        n_waddr   = r_waddr;
        n_wdata   = r_wdata;
        if (r_stop) begin
            n_state = S_IDLE;
            n_sda   = 1'b1;
            n_busy  = 1'b0;
        end else if (r_start) begin
            n_state  = S_ADDR;
            n_bitcnt = '0;
            n_sda    = 1'b1;
        end else if (r_scl_rise) begin
            case (r_state)
                S_ADDR: begin
                    n_shift  = w_byte;
                    n_bitcnt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        if (w_byte[7:1] == ADDR) begin
                            n_state   = S_ADDR_ACK;
                            n_ack_clk = 1'b0;
                            n_rw      = w_byte[0];
                            n_first   = 1'b1;
                            if (w_byte[0])
                                n_snap = {y[9:8], x[9:8], size, y[7:0], x[7:0]};
                        end else begin
                            n_state = S_IGNORE;
                            n_busy  = 1'b0;
                        end
                    end
                end
                S_WR_BYTE: begin
                    n_shift  = w_byte;
                    n_bitcnt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        n_state   = S_WR_ACK;
                        n_ack_clk = 1'b0;
                        if (r_first) begin
                            n_ptr   = w_byte;
                            n_first = 1'b0;
                        end else begin
                            n_wr    = 1'b1;
                            n_waddr = r_ptr;
                            n_wdata = w_byte;
                            if (r_ptr == 8'h30) n_ctrl = w_byte;
                            if (r_ptr == 8'h33) n_mode = w_byte;
                            n_ptr = r_ptr + 8'd1;
                        end
                    end
                end
                S_RD_BYTE: begin
                    n_bitcnt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        n_state   = S_RD_ACK;
                        n_ack_clk = 1'b0;
                    end
                end
                S_ADDR_ACK, S_WR_ACK: n_ack_clk = 1'b1;
                S_RD_ACK: begin
                    if (r_sda_d) n_state = S_IGNORE;
                    else         n_ack_clk = 1'b1;
                end
                default: ;
            endcase
        end else if (r_scl_fall) begin
            case (r_state)
                S_ADDR_ACK, S_WR_ACK: begin
                    if (!r_ack_clk) begin
                        n_sda = 1'b0;
                        if (r_state == S_ADDR_ACK) n_busy = 1'b1;
                    end else if (r_state == S_ADDR_ACK && r_rw) begin
                        n_state  = S_RD_BYTE;
                        n_bitcnt = '0;
                        n_sda    = w_rd_byte[7];
                        n_tx     = {w_rd_byte[6:0], 1'b0};
                        n_ptr    = r_ptr + 8'd1;
                    end else begin
                        n_state  = S_WR_BYTE;
                        n_bitcnt = '0;
                        n_sda    = 1'b1;
                    end
                end
                S_RD_BYTE: begin
                    n_sda = r_tx[7];
                    n_tx  = {r_tx[6:0], 1'b0};
                end
                S_RD_ACK: begin
                    if (!r_ack_clk) begin
                        n_sda = 1'b1;
                    end else begin
                        n_state  = S_RD_BYTE;
                        n_bitcnt = '0;
                        n_sda    = w_rd_byte[7];
                        n_tx     = {w_rd_byte[6:0], 1'b0};
                        n_ptr    = r_ptr + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_ack_clk <= 1'b0;
            r_rw      <= 1'b0;
            r_first   <= 1'b0;
            r_ptr     <= '0;
            r_snap    <= '0;
            r_sda     <= 1'b1;
            r_busy    <= 1'b0;
            r_ctrl    <= '0;
            r_mode    <= '0;
            r_wr      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= n_state;
            r_bitcnt  <= n_bitcnt;
            r_shift   <= n_shift;
            r_tx      <= n_tx;
            r_ack_clk <= n_ack_clk;
            r_rw      <= n_rw;
            r_first   <= n_first;
            r_ptr     <= n_ptr;
            r_snap    <= n_snap;
            r_sda     <= n_sda;
            r_busy    <= n_busy;
            r_ctrl    <= n_ctrl;
            r_mode    <= n_mode;
            r_wr      <= n_wr;
            r_waddr   <= n_waddr;
            r_wdata   <= n_wdata;
        end
    end

    assign i2c_sda  = r_sda;
    assign reg_wr   = r_wr;
    assign reg_addr = r_waddr;
    assign reg_data = r_wdata;
    assign ctrl     = r_ctrl;
    assign mode     = r_mode;
    assign enabled  = r_ctrl[3];
    assign busy     = r_busy;
endmodule
